cs_bus_arbiter: RTL and testbench
=================================

# cs_bus_arbiter

Two-requester shared-bus arbiter and chip-select sequencer for the arcade board memory map. It grants the shared address bus to either the CPU or the video scanner, and decodes the granted address into four active-low chip selects (bank = addr[15:14], same polarity and one-hot-low encoding as the board's 2-to-4 decoders). It holds each access for a per-bank number of wait states, then returns a single-cycle acknowledge to the winner.

## Interface
Parameters:
- AW, 16, address width; bank select is always addr[AW-1:AW-2].
- WS0, 0, wait states for bank 0 (range 0..3).
- WS1, 1, wait states for bank 1 (range 0..3).
- WS2, 1, wait states for bank 2 (range 0..3).
- WS3, 2, wait states for bank 3 (range 0..3).

Ports:
- clk_sys  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_addr  in  AW  CPU address; stable while cpu_req high.
- cpu_ack  out  1  one-cycle pulse, CPU access complete.
- vid_req  in  1  video scanner access request; held until vid_ack.
- vid_addr  in  AW  video address; stable while vid_req high.
- vid_ack  out  1  one-cycle pulse, video access complete.
- bus_addr  out  AW  latched address of the granted requester.
- cs_n  out  4  active-low one-hot chip selects, 4'b1111 when idle.
- owner  out  1  0 = CPU granted, 1 = video granted.
- busy  out  1  high in ACCESS and RELEASE.

## Operation
- All outputs registered. Reset values: cs_n=4'b1111, cpu_ack=0, vid_ack=0, bus_addr=0, owner=0, busy=0. Internal state: state=IDLE, wait counter=0, last_owner=1, so the CPU wins the first tie.
- FSM states: IDLE, ACCESS, RELEASE.
- IDLE, no request: stay; cs_n=1111.
- IDLE, exactly one req high: grant that requester.
- IDLE, both req high: grant the requester opposite to last_owner (round-robin).
- On grant: latch the winner's address into bus_addr; set owner and last_owner; load the 2-bit counter with WS[bank]; go to ACCESS.
- ACCESS: cs_n = ~(4'b0001 << bus_addr[AW-1:AW-2]). Counter decrements each cycle. When counter==0, go to RELEASE. ACCESS lasts WS[bank]+1 cycles.
- RELEASE: cs_n=1111. Ack of the owner is 1 for exactly this cycle; the other ack stays 0. Next state is IDLE. bus_addr and owner hold their value until the next grant.
- Requester rule: drop req in the cycle after ack is seen. IDLE samples req at the end of its cycle, so a dropped req is never re-granted.
- Dropping req during ACCESS does not abort the access. It completes and the ack still pulses.
- A request arriving during ACCESS/RELEASE waits; it is arbitrated in the next IDLE.
- Reset asserted in any state: at the next edge, reset values apply. cs_n returns to 1111 and no ack is issued for the aborted access.
- cpu_ack and vid_ack are never high together. cs_n never has more than one bit low.

## Timing
- req sampled high in IDLE at edge N gives:
  - ACCESS from cycle N+1; cs_n low for cycles N+1 .. N+1+WS.
  - RELEASE (ack=1) at cycle N+2+WS.
  - IDLE at cycle N+3+WS.
- Request-to-ack latency is WS+2 cycles. A back-to-back access costs WS+3 cycles, including the one IDLE cycle.
- Minimum cycle (WS=0): grant, 1 ACCESS cycle, RELEASE, IDLE = 3 cycles per access.

## Test plan
- Single CPU access, cpu_addr=16'h1234 (bank 0, WS0=0) -> bus_addr=16'h1234, owner=0, cs_n=4'b1110 for 1 cycle, cpu_ack pulse 2 cycles after req sampled, vid_ack stays 0.
- Video access, vid_addr=16'hC000 (bank 3, WS3=2) -> owner=1, cs_n=4'b0111 for 3 cycles, then vid_ack for 1 cycle with cs_n=1111.
- Both requests held continuously from reset, CPU bank 1, video bank 2 -> grants alternate CPU, video, CPU, video (CPU first). cs_n alternates 4'b1101 / 4'b1011. No cycle has both acks high.
- Reset pulsed in the second ACCESS cycle of a WS3 access -> next cycle cs_n=1111, busy=0, no ack. A still-held req is re-granted from IDLE with a full WS+1 ACCESS.
- cpu_req dropped mid-ACCESS (bank 1) -> access runs to completion: cs_n=4'b1101 for 2 cycles, cpu_ack still pulses once, then IDLE with no new grant.
- Video request raised during a CPU ACCESS -> video is granted in the first IDLE after the CPU's RELEASE, with bus_addr=vid_addr.

Source files
------------

// File: rtl/cs_bus_arbiter_if.sv
// Shared-bus bundle between the CPU / video requesters and the arbiter.
// The master side issues requests; the slave side is the arbiter.
interface cs_bus_arbiter_if #(
  parameter int AW = 16
);
  logic          cpu_req;
  logic [AW-1:0] cpu_addr;
  logic          cpu_ack;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic [AW-1:0] bus_addr;
  logic [3:0]    cs_n;
  logic          owner;
  logic          busy;

  modport master (
    output cpu_req, cpu_addr, vid_req, vid_addr,
    input  cpu_ack, vid_ack, bus_addr, cs_n, owner, busy
  );

  modport slave (
    input  cpu_req, cpu_addr, vid_req, vid_addr,
    output cpu_ack, vid_ack, bus_addr, cs_n, owner, busy
  );
endinterface

// File: rtl/cs_bus_arbiter.sv
// Round-robin CPU/video bus arbiter with per-bank wait states and
// active-low one-hot chip selects decoded from the top two address bits.
module cs_bus_arbiter #(
  parameter int AW  = 16,
  parameter int WS0 = 0,
  parameter int WS1 = 1,
  parameter int WS2 = 1,
  parameter int WS3 = 2
) (
  input  logic clk_sys,
  input  logic reset,
  cs_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  state_t        state, state_d;
  logic [1:0]    cnt, cnt_d;
  logic          last_owner, last_owner_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]    cs_n_q, cs_n_d;
  logic          owner_q, owner_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          vid_ack_q, vid_ack_d;
  logic          busy_q, busy_d;
  logic          grant_vid;
  logic [AW-1:0] win_addr;

  function automatic logic [1:0] ws_of(input logic [1:0] bank);
    case (bank)
      2'd0:    ws_of = 2'(WS0);
      2'd1:    ws_of = 2'(WS1);
      2'd2:    ws_of = 2'(WS2);
      default: ws_of = 2'(WS3);
    endcase
  endfunction

  function automatic logic [3:0] cs_of(input logic [1:0] bank);
    cs_of = ~(4'b0001 << bank);
  endfunction

  // On a tie the requester that did not win last time gets the bus.
  assign grant_vid = bus.vid_req && (!bus.cpu_req || !last_owner);
  assign win_addr  = grant_vid ? bus.vid_addr : bus.cpu_addr;

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    last_owner_d = last_owner;
    bus_addr_d   = bus_addr_q;
    owner_d      = owner_q;
    cs_n_d       = 4'b1111;
    cpu_ack_d    = 1'b0;
    vid_ack_d    = 1'b0;
    busy_d       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cpu_req || bus.vid_req) begin
          state_d      = ACCESS;
          bus_addr_d   = win_addr;
          owner_d      = grant_vid;
          last_owner_d = grant_vid;
          cnt_d        = ws_of(win_addr[AW-1:AW-2]);
          cs_n_d       = cs_of(win_addr[AW-1:AW-2]);
          busy_d       = 1'b1;
        end
      end
      ACCESS: begin
        busy_d = 1'b1;
        if (cnt == 2'd0) begin
          state_d   = RELEASE;
          cpu_ack_d = !owner_q;
          vid_ack_d = owner_q;
        end else begin
          cnt_d  = cnt - 2'd1;
          cs_n_d = cs_of(bus_addr_q[AW-1:AW-2]);
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered alongside the state, so they line up with it.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      last_owner <= 1'b1;
      bus_addr_q <= '0;
      owner_q    <= 1'b0;
      cs_n_q     <= 4'b1111;
      cpu_ack_q  <= 1'b0;
      vid_ack_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      last_owner <= last_owner_d;
      bus_addr_q <= bus_addr_d;
      owner_q    <= owner_d;
      cs_n_q     <= cs_n_d;
      cpu_ack_q  <= cpu_ack_d;
      vid_ack_q  <= vid_ack_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.bus_addr = bus_addr_q;
  assign bus.cs_n     = cs_n_q;
  assign bus.owner    = owner_q;
  assign bus.cpu_ack  = cpu_ack_q;
  assign bus.vid_ack  = vid_ack_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_cs_bus_arbiter.sv
// Directed per-cycle vector bench for cs_bus_arbiter with default wait states,
// plus a bounded request-to-ack latency sequence.
module tb_cs_bus_arbiter;

  typedef struct {
    string       name;
    logic        rst;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        cpu_ack;
    logic        vid_ack;
    logic [15:0] bus_addr;
    logic [3:0]  cs_n;
    logic        owner;
    logic        busy;
  } vec_t;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   n_compared   = 0;
  int   n_mismatched = 0;
  vec_t vecs[$];

  cs_bus_arbiter_if #(.AW(16)) bus_if ();

  cs_bus_arbiter #(
    .AW(16), .WS0(0), .WS1(1), .WS2(1), .WS3(2)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus_if)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic addVec(input string nm, input logic r, input logic cr, input logic [15:0] ca,
                        input logic vr, input logic [15:0] va, input logic eca, input logic eva,
                        input logic [15:0] eba, input logic [3:0] ecs, input logic eo, input logic eb);
    vec_t v;
    v.name = nm; v.rst = r; v.cpu_req = cr; v.cpu_addr = ca; v.vid_req = vr; v.vid_addr = va;
    v.cpu_ack = eca; v.vid_ack = eva; v.bus_addr = eba; v.cs_n = ecs; v.owner = eo; v.busy = eb;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk_sys);
    reset           = v.rst;
    bus_if.cpu_req  = v.cpu_req;
    bus_if.cpu_addr = v.cpu_addr;
    bus_if.vid_req  = v.vid_req;
    bus_if.vid_addr = v.vid_addr;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic checkOutput(input vec_t v);
    logic [23:0] got, exp;
    got = {bus_if.cpu_ack, bus_if.vid_ack, bus_if.bus_addr, bus_if.cs_n, bus_if.owner, bus_if.busy};
    exp = {v.cpu_ack, v.vid_ack, v.bus_addr, v.cs_n, v.owner, v.busy};
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: {cpu_ack,vid_ack,bus_addr,cs_n,owner,busy} got %b %b %h %b %b %b expected %b %b %h %b %b %b",
               v.name, got[23], got[22], got[21:6], got[5:2], got[1], got[0],
               exp[23], exp[22], exp[21:6], exp[5:2], exp[1], exp[0]);
    end
    n_compared++;
    if (bus_if.cpu_ack && bus_if.vid_ack) begin
      n_mismatched++;
      $display("[TB] FAIL %s both_acks: got cpu_ack=1 vid_ack=1 expected at most one", v.name);
    end
    n_compared++;
    if ($countones(~bus_if.cs_n) > 1) begin
      n_mismatched++;
      $display("[TB] FAIL %s cs_onehot: got cs_n=%b expected at most one low bit", v.name, bus_if.cs_n);
    end
  endtask

  initial begin
    int lat;
    bus_if.cpu_req  = 1'b0;
    bus_if.cpu_addr = 16'h0;
    bus_if.vid_req  = 1'b0;
    bus_if.vid_addr = 16'h0;

    // name, rst, cpu_req, cpu_addr, vid_req, vid_addr | cpu_ack, vid_ack, bus_addr, cs_n, owner, busy
    addVec("reset",      1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 4'b1111, 0, 0);
    addVec("cpu_grant",  0, 1, 16'h1234, 0, 16'h0000, 0, 0, 16'h1234, 4'b1110, 0, 1);
    addVec("cpu_rel",    0, 1, 16'h1234, 0, 16'h0000, 1, 0, 16'h1234, 4'b1111, 0, 1);
    addVec("cpu_idle",   0, 0, 16'h1234, 0, 16'h0000, 0, 0, 16'h1234, 4'b1111, 0, 0);
    addVec("idle2",      0, 0, 16'h1234, 0, 16'h0000, 0, 0, 16'h1234, 4'b1111, 0, 0);
    addVec("vid_grant",  0, 0, 16'h0000, 1, 16'hC000, 0, 0, 16'hC000, 4'b0111, 1, 1);
    addVec("vid_acc2",   0, 0, 16'h0000, 1, 16'hC000, 0, 0, 16'hC000, 4'b0111, 1, 1);
    addVec("vid_acc3",   0, 0, 16'h0000, 1, 16'hC000, 0, 0, 16'hC000, 4'b0111, 1, 1);
    addVec("vid_rel",    0, 0, 16'h0000, 1, 16'hC000, 0, 1, 16'hC000, 4'b1111, 1, 1);
    addVec("vid_idle",   0, 0, 16'h0000, 0, 16'hC000, 0, 0, 16'hC000, 4'b1111, 1, 0);
    // Both requesters held from reset: CPU wins the first tie, then alternate.
    addVec("rr_reset",   1, 1, 16'h4000, 1, 16'h8000, 0, 0, 16'h0000, 4'b1111, 0, 0);
    addVec("rr_cpu_g",   0, 1, 16'h4000, 1, 16'h8000, 0, 0, 16'h4000, 4'b1101, 0, 1);
    addVec("rr_cpu_a",   0, 1, 16'h4000, 1, 16'h8000, 0, 0, 16'h4000, 4'b1101, 0, 1);
    addVec("rr_cpu_r",   0, 1, 16'h4000, 1, 16'h8000, 1, 0, 16'h4000, 4'b1111, 0, 1);
    addVec("rr_idle1",   0, 1, 16'h4000, 1, 16'h8000, 0, 0, 16'h4000, 4'b1111, 0, 0);
    addVec("rr_vid_g",   0, 1, 16'h4000, 1, 16'h8000, 0, 0, 16'h8000, 4'b1011, 1, 1);
    addVec("rr_vid_a",   0, 1, 16'h4000, 1, 16'h8000, 0, 0, 16'h8000, 4'b1011, 1, 1);
    addVec("rr_vid_r",   0, 1, 16'h4000, 1, 16'h8000, 0, 1, 16'h8000, 4'b1111, 1, 1);
    addVec("rr_idle2",   0, 1, 16'h4000, 1, 16'h8000, 0, 0, 16'h8000, 4'b1111, 1, 0);
    addVec("rr_cpu_g2",  0, 1, 16'h4000, 1, 16'h8000, 0, 0, 16'h4000, 4'b1101, 0, 1);
    addVec("rr_cpu_a2",  0, 1, 16'h4000, 1, 16'h8000, 0, 0, 16'h4000, 4'b1101, 0, 1);
    addVec("rr_cpu_r2",  0, 1, 16'h4000, 1, 16'h8000, 1, 0, 16'h4000, 4'b1111, 0, 1);
    addVec("rr_idle3",   0, 1, 16'h4000, 1, 16'h8000, 0, 0, 16'h4000, 4'b1111, 0, 0);
    addVec("rr_vid_g2",  0, 1, 16'h4000, 1, 16'h8000, 0, 0, 16'h8000, 4'b1011, 1, 1);
    // Reset in the second ACCESS cycle of a bank-3 access, then full re-grant.
    addVec("ra_reset",   1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 4'b1111, 0, 0);
    addVec("ra_grant",   0, 1, 16'hC100, 0, 16'h0000, 0, 0, 16'hC100, 4'b0111, 0, 1);
    addVec("ra_acc2",    0, 1, 16'hC100, 0, 16'h0000, 0, 0, 16'hC100, 4'b0111, 0, 1);
    addVec("ra_abort",   1, 1, 16'hC100, 0, 16'h0000, 0, 0, 16'h0000, 4'b1111, 0, 0);
    addVec("ra_regrant", 0, 1, 16'hC100, 0, 16'h0000, 0, 0, 16'hC100, 4'b0111, 0, 1);
    addVec("ra_racc2",   0, 1, 16'hC100, 0, 16'h0000, 0, 0, 16'hC100, 4'b0111, 0, 1);
    addVec("ra_racc3",   0, 1, 16'hC100, 0, 16'h0000, 0, 0, 16'hC100, 4'b0111, 0, 1);
    addVec("ra_rel",     0, 1, 16'hC100, 0, 16'h0000, 1, 0, 16'hC100, 4'b1111, 0, 1);
    addVec("ra_idle",    0, 0, 16'hC100, 0, 16'h0000, 0, 0, 16'hC100, 4'b1111, 0, 0);
    // CPU drops its request mid-access; the access still completes.
    addVec("dr_grant",   0, 1, 16'h5678, 0, 16'h0000, 0, 0, 16'h5678, 4'b1101, 0, 1);
    addVec("dr_acc2",    0, 0, 16'h5678, 0, 16'h0000, 0, 0, 16'h5678, 4'b1101, 0, 1);
    addVec("dr_rel",     0, 0, 16'h5678, 0, 16'h0000, 1, 0, 16'h5678, 4'b1111, 0, 1);
    addVec("dr_idle",    0, 0, 16'h5678, 0, 16'h0000, 0, 0, 16'h5678, 4'b1111, 0, 0);
    addVec("dr_nogrant", 0, 0, 16'h5678, 0, 16'h0000, 0, 0, 16'h5678, 4'b1111, 0, 0);
    // Video request arrives during a CPU access and waits for the next IDLE.
    addVec("vw_cpu_g",   0, 1, 16'h2000, 0, 16'h0000, 0, 0, 16'h2000, 4'b1110, 0, 1);
    addVec("vw_cpu_r",   0, 1, 16'h2000, 1, 16'h9ABC, 1, 0, 16'h2000, 4'b1111, 0, 1);
    addVec("vw_idle",    0, 0, 16'h2000, 1, 16'h9ABC, 0, 0, 16'h2000, 4'b1111, 0, 0);
    addVec("vw_vid_g",   0, 0, 16'h2000, 1, 16'h9ABC, 0, 0, 16'h9ABC, 4'b1011, 1, 1);
    addVec("vw_vid_a",   0, 0, 16'h2000, 1, 16'h9ABC, 0, 0, 16'h9ABC, 4'b1011, 1, 1);
    addVec("vw_vid_r",   0, 0, 16'h2000, 1, 16'h9ABC, 0, 1, 16'h9ABC, 4'b1111, 1, 1);
    addVec("vw_end",     0, 0, 16'h2000, 0, 16'h9ABC, 0, 0, 16'h9ABC, 4'b1111, 1, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // Bank-1 video request: ack must arrive WS1+2 = 3 edges after the request.
    @(negedge clk_sys);
    bus_if.vid_addr = 16'h4444;
    bus_if.vid_req  = 1'b1;
    lat = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_sys);
      #1;
      lat++;
      if (bus_if.vid_ack) break;
    end
    n_compared++;
    if (!bus_if.vid_ack || lat != 3) begin
      n_mismatched++;
      $display("[TB] FAIL vid_latency: got %0d cycles (ack=%b) expected 3 cycles", lat, bus_if.vid_ack);
    end
    @(negedge clk_sys);
    bus_if.vid_req = 1'b0;
    @(posedge clk_sys);
    #1;
    n_compared++;
    if (bus_if.busy !== 1'b0 || bus_if.vid_ack !== 1'b0 || bus_if.cs_n !== 4'b1111) begin
      n_mismatched++;
      $display("[TB] FAIL lat_idle: got busy=%b vid_ack=%b cs_n=%b expected 0 0 1111",
               bus_if.busy, bus_if.vid_ack, bus_if.cs_n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
